// File: rtl/i2s_pkg.sv
// Shared types and slot-mapping helper for the I2S DAC transmitter.
// I2S_TX_LEFT_JUSTIFIED_EN selects left-justified framing with lrclk=1 on the left slot.
package i2s_pkg;

   localparam int unsigned SLOT_W     = 32;
   localparam int unsigned FRAME_BITS = 64;
   localparam int unsigned BIT_CNT_W  = 6;

   typedef enum logic {
      StIdle = 1'b0,
      StRun  = 1'b1
   } state_e;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
   localparam logic LRCLK_LEFT = 1'b1;
`else
   localparam logic LRCLK_LEFT = 1'b0;
`endif

   // MSB-first sample bit index driven at bit_cnt, or -1 for slot padding.
   function automatic int slot_bit(input int unsigned sample_w,
                                   input logic [BIT_CNT_W-1:0] bit_cnt);
      int pos;
      pos = int'(bit_cnt) % int'(SLOT_W);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
      if (pos < int'(sample_w)) begin
         return pos;
      end
`else
      // Standard I2S delays the MSB by one bclk after the lrclk edge.
      if ((pos >= 1) && (pos <= int'(sample_w))) begin
         return pos - 1;
      end
`endif
      return -1;
   endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Clock-enable divider producing bclk, a fall strobe and the 0..63 bit counter.
// Held at zero while en_i is low.
module i2s_clk_gen
   import i2s_pkg::*;
#(
   parameter int unsigned BCLK_DIV = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 en_i,
   output logic                 bclk_o,
   output logic                 bclk_fall_o,
   output logic [BIT_CNT_W-1:0] bit_cnt_o
);

   localparam int unsigned     DivW    = $clog2(BCLK_DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(BCLK_DIV - 1);

   logic [DivW-1:0]      div_cnt_q, div_cnt_d;
   logic                 bclk_q, bclk_d;
   logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic                 div_tc;

   always_comb begin : div_next
      div_tc    = (div_cnt_q == DivLast);
      div_cnt_d = div_cnt_q;
      bclk_d    = bclk_q;
      bit_cnt_d = bit_cnt_q;
      if (!en_i) begin
         div_cnt_d = '0;
         bclk_d    = 1'b0;
         bit_cnt_d = '0;
      end else if (div_tc) begin
         div_cnt_d = '0;
         bclk_d    = ~bclk_q;
         if (bclk_q) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
         end
      end else begin
         div_cnt_d = div_cnt_q + DivW'(1);
      end
   end

   always_ff @(posedge clock) begin : div_regs
      if (reset) begin
         div_cnt_q <= '0;
         bclk_q    <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         div_cnt_q <= div_cnt_d;
         bclk_q    <= bclk_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   // Strobe is high in the cycle whose closing edge drives bclk low.
   assign bclk_fall_o = en_i && div_tc && bclk_q;
   assign bclk_o      = bclk_q;
   assign bit_cnt_o   = bit_cnt_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S serialiser for the ADAU1761 DAC path; bclk/lrclk are clock-enable divided from clock.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified framing (lrclk=1 marks the left slot).
module i2s_dac_tx
   import i2s_pkg::*;
#(
   parameter int unsigned BCLK_DIV = 16,
   parameter int unsigned SAMPLE_W = 24
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] in_left,
   input  logic [SAMPLE_W-1:0] in_right,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                bclk,
   output logic                lrclk,
   output logic                sdata,
   output logic                underrun
);

   localparam int unsigned IdxW = (SAMPLE_W > 1) ? $clog2(SAMPLE_W) : 1;

   state_e               state_q, state_d;
   logic                 pend_full_q, pend_full_d;
   logic [SAMPLE_W-1:0]  pend_left_q, pend_left_d;
   logic [SAMPLE_W-1:0]  pend_right_q, pend_right_d;
   logic [SAMPLE_W-1:0]  left_q, left_d;
   logic [SAMPLE_W-1:0]  right_q, right_d;
   logic                 lrclk_q, lrclk_d;
   logic                 sdata_q, sdata_d;
   logic                 underrun_q, underrun_d;

   logic                 clk_en;
   logic                 first_load;
   logic                 bclk_fall;
   logic                 accept;
   logic                 load;
   logic                 update;
   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [BIT_CNT_W-1:0] tx_bit;
   logic [SAMPLE_W-1:0]  tx_word;
   logic [IdxW-1:0]      word_idx;
   int                   slot_idx;

   i2s_clk_gen #(
      .BCLK_DIV(BCLK_DIV)
   ) u_clk_gen (
      .clock      (clock),
      .reset      (reset),
      .en_i       (clk_en),
      .bclk_o     (bclk),
      .bclk_fall_o(bclk_fall),
      .bit_cnt_o  (bit_cnt)
   );

   always_ff @(posedge clock) begin : state_reg
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : state_next
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (pend_full_q) state_d = StRun;
         StRun:   state_d = StRun;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin : state_out
      clk_en     = 1'b0;
      first_load = 1'b0;
      unique case (state_q)
         StIdle:  first_load = pend_full_q;
         StRun:   clk_en = 1'b1;
         default: ;
      endcase
   end

   always_comb begin : data_next
      accept = in_valid && !pend_full_q;
      update = first_load || (clk_en && bclk_fall);
      load   = first_load ||
               (clk_en && bclk_fall && (bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)));
      // Outputs are registered, so they are computed for the bit that starts at the fall.
      tx_bit = first_load ? '0 : bit_cnt + BIT_CNT_W'(1);

      pend_full_d  = pend_full_q;
      pend_left_d  = pend_left_q;
      pend_right_d = pend_right_q;
      if (load) begin
         pend_full_d = 1'b0;
      end
      if (accept) begin
         pend_full_d  = 1'b1;
         pend_left_d  = in_left;
         pend_right_d = in_right;
      end

      left_d     = left_q;
      right_d    = right_q;
      underrun_d = 1'b0;
      if (load) begin
         if (pend_full_q) begin
            left_d  = pend_left_q;
            right_d = pend_right_q;
         end else begin
            underrun_d = 1'b1;
         end
      end

      tx_word  = tx_bit[BIT_CNT_W-1] ? right_d : left_d;
      slot_idx = slot_bit(SAMPLE_W, tx_bit);
      word_idx = IdxW'(int'(SAMPLE_W) - 1 - slot_idx);

      lrclk_d = lrclk_q;
      sdata_d = sdata_q;
      if (update) begin
         lrclk_d = tx_bit[BIT_CNT_W-1] ? ~LRCLK_LEFT : LRCLK_LEFT;
         sdata_d = (slot_idx < 0) ? 1'b0 : tx_word[word_idx];
      end
   end

   always_ff @(posedge clock) begin : data_regs
      if (reset) begin
         pend_full_q  <= 1'b0;
         pend_left_q  <= '0;
         pend_right_q <= '0;
         left_q       <= '0;
         right_q      <= '0;
         lrclk_q      <= 1'b1;
         sdata_q      <= 1'b0;
         underrun_q   <= 1'b0;
      end else begin
         pend_full_q  <= pend_full_d;
         pend_left_q  <= pend_left_d;
         pend_right_q <= pend_right_d;
         left_q       <= left_d;
         right_q      <= right_d;
         lrclk_q      <= lrclk_d;
         sdata_q      <= sdata_d;
         underrun_q   <= underrun_d;
      end
   end

   assign in_ready = !pend_full_q;
   assign lrclk    = lrclk_q;
   assign sdata    = sdata_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: decodes sdata at bclk rises and checks framing and timing.
module tb_i2s_dac_tx;

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
   localparam int   MsbPos    = 0;
   localparam logic LeftLr    = 1'b1;
   localparam int   LrEdges16 = 20;
`else
   localparam int   MsbPos    = 1;
   localparam logic LeftLr    = 1'b0;
   localparam int   LrEdges16 = 21;
`endif
   localparam int LogN = 1024;

   logic        clock = 1'b0;
   logic        reset, in_valid, in_ready, bclk, lrclk, sdata, underrun;
   logic [23:0] in_left, in_right;
   logic        reset16, in_valid16, in_ready16, bclk16, lrclk16, sdata16, underrun16;
   logic [23:0] in_left16, in_right16;

   int n_vec = 0;
   int n_err = 0;

   // Monitor state, written only by the monitor process.
   int   cyc = 0;
   int   rise_n = 0;
   logic sd_log [0:LogN-1];
   logic lr_log [0:LogN-1];
   int   rise_cyc [0:LogN-1];
   int   un_q [$];
   logic bclk_prev;
   int   b16_edges, b16_bad, b16_last, lr16_edges, lr16_bad, lr16_last;
   int   un16, rise16, ones16;
   logic b16_prev, lr16_prev;

   i2s_dac_tx #(
      .BCLK_DIV(2),
      .SAMPLE_W(24)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .in_left (in_left),
      .in_right(in_right),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .bclk    (bclk),
      .lrclk   (lrclk),
      .sdata   (sdata),
      .underrun(underrun)
   );

   i2s_dac_tx #(
      .BCLK_DIV(16),
      .SAMPLE_W(24)
   ) dut16 (
      .clock   (clock),
      .reset   (reset16),
      .in_left (in_left16),
      .in_right(in_right16),
      .in_valid(in_valid16),
      .in_ready(in_ready16),
      .bclk    (bclk16),
      .lrclk   (lrclk16),
      .sdata   (sdata16),
      .underrun(underrun16)
   );

   initial forever #5 clock = ~clock;

   initial begin
      forever begin
         @(negedge clock);
         cyc++;
         if (reset) begin
            rise_n = 0;
            un_q.delete();
            bclk_prev = 1'b0;
         end else begin
            if (bclk && !bclk_prev && rise_n < LogN) begin
               sd_log[rise_n]   = sdata;
               lr_log[rise_n]   = lrclk;
               rise_cyc[rise_n] = cyc;
               rise_n++;
            end
            bclk_prev = bclk;
            if (underrun) un_q.push_back(cyc);
         end
         if (reset16) begin
            b16_edges = 0; b16_bad = 0; b16_last = -1; b16_prev = 1'b0;
            lr16_edges = 0; lr16_bad = 0; lr16_last = -1; lr16_prev = 1'b1;
            un16 = 0; rise16 = 0; ones16 = 0;
         end else begin
            if (bclk16 != b16_prev) begin
               if (b16_last >= 0 && cyc - b16_last != 16) b16_bad++;
               b16_last = cyc;
               b16_edges++;
               if (bclk16) begin
                  if (rise16 < 640 && sdata16) ones16++;
                  rise16++;
               end
               b16_prev = bclk16;
            end
            if (lrclk16 != lr16_prev) begin
               if (lr16_last >= 0 && cyc - lr16_last != 1024) lr16_bad++;
               lr16_last = cyc;
               lr16_edges++;
               lr16_prev = lrclk16;
            end
            if (underrun16) un16++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] get_word(input int base);
      logic [23:0] w = '0;
      for (int i = 0; i < 24; i++) w = {w[22:0], sd_log[base + MsbPos + i]};
      return w;
   endfunction

   function automatic int pad_errs(input int base);
      int e = 0;
      int pos;
      for (int b = 0; b < 64; b++) begin
         pos = b % 32;
         if (sd_log[base + b] && (pos < MsbPos || pos > MsbPos + 23)) e++;
      end
      return e;
   endfunction

   function automatic int lr_errs(input int base);
      int e = 0;
      for (int b = 0; b < 64; b++) begin
         if (lr_log[base + b] !== ((b < 32) ? LeftLr : ~LeftLr)) e++;
      end
      return e;
   endfunction

   task automatic check_frame(input string tag, input int f, input logic [23:0] l,
                              input logic [23:0] r);
      check({tag, "_left"}, 32'(get_word(f * 64)), 32'(l));
      check({tag, "_right"}, 32'(get_word(f * 64 + 32)), 32'(r));
      check({tag, "_pad"}, pad_errs(f * 64), 0);
      check({tag, "_lrclk"}, lr_errs(f * 64), 0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
      int n = 0;
      while (!in_ready && n < 2000) begin
         @(posedge clock);
         #1 n++;
      end
      if (!in_ready) check("ready_timeout", 32'(in_ready), 1);
      in_left  = l;
      in_right = r;
      in_valid = 1'b1;
      @(posedge clock);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_rises(input int target, input int budget);
      int n = 0;
      while (rise_n < target && n < budget) begin
         @(posedge clock);
         n++;
      end
      #1;
      if (rise_n < target) check("rise_timeout", rise_n, target);
   endtask

   initial begin
      int n;
      int tail;
      reset = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0;
      reset16 = 1'b1; in_valid16 = 1'b0; in_left16 = '0; in_right16 = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(posedge clock);
      #1;
      check("rst_bclk", 32'(bclk), 0);
      check("rst_lrclk", 32'(lrclk), 1);
      check("rst_sdata", 32'(sdata), 0);
      check("rst_underrun", 32'(underrun), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      repeat (20) @(posedge clock);
      #1 check("idle_quiet", rise_n, 0);

      // One pair, then starve: three identical frames with an underrun per wrap.
      send_pair(24'hA55AC3, 24'h123456);
      check("ready_after_accept", 32'(in_ready), 0);
      wait_rises(3 * 64, 1000);
      check_frame("f0", 0, 24'hA55AC3, 24'h123456);
      check_frame("f1", 1, 24'hA55AC3, 24'h123456);
      check_frame("f2", 2, 24'hA55AC3, 24'h123456);
      check("bclk_period", rise_cyc[1] - rise_cyc[0], 4);
      check("urun_count", un_q.size(), 2);
      check("urun_first", (un_q.size() > 0) ? un_q[0] - rise_cyc[0] : -1, 254);
      check("urun_period", (un_q.size() > 1) ? un_q[1] - un_q[0] : -1, 256);

      // Back-to-back pairs with valid held high.
      do_reset();
      in_left = 24'h7FFFFF; in_right = 24'h800000; in_valid = 1'b1;
      @(posedge clock);
      #1 check("b2b_p1_taken", 32'(in_ready), 0);
      in_left = 24'h000001; in_right = 24'hFFFFFE;
      @(posedge clock);
      #1 check("b2b_ready_after_load", 32'(in_ready), 1);
      @(posedge clock);
      #1 check("b2b_p2_taken", 32'(in_ready), 0);
      in_valid = 1'b0;
      wait_rises(2 * 64 + 1, 700);
      check_frame("b2b_f0", 0, 24'h7FFFFF, 24'h800000);
      check_frame("b2b_f1", 1, 24'h000001, 24'hFFFFFE);
      check("b2b_urun_count", un_q.size(), 1);
      check("b2b_urun_at", (un_q.size() > 0) ? un_q[0] - rise_cyc[0] : -1, 510);
      check("b2b_ready_end", 32'(in_ready), 1);

      // Reset at bit_cnt 40 with a second pair pending.
      do_reset();
      send_pair(24'h111111, 24'h222222);
      send_pair(24'h333333, 24'h444444);
      check("mid_pending", 32'(in_ready), 0);
      wait_rises(41, 400);
      @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      check("mid_rst_bclk", 32'(bclk), 0);
      check("mid_rst_lrclk", 32'(lrclk), 1);
      check("mid_rst_sdata", 32'(sdata), 0);
      check("mid_rst_ready", 32'(in_ready), 1);
      check("mid_rst_underrun", 32'(underrun), 0);
      repeat (20) @(posedge clock);
      #1 check("mid_rst_idle", rise_n, 0);
      send_pair(24'h800001, 24'h400002);
      wait_rises(64, 400);
      check_frame("restart", 0, 24'h800001, 24'h400002);
      check("restart_msb", 32'(sd_log[MsbPos]), 1);
      check("restart_lsb", 32'(sd_log[MsbPos + 23]), 1);
      tail = 0;
      for (int b = MsbPos + 24; b < 32; b++) if (sd_log[b]) tail++;
      check("restart_tail_zero", tail, 0);
      check("restart_lr_bit0", 32'(lr_log[0]), 32'(LeftLr));

      // BCLK_DIV=16 over ten frames.
      @(posedge clock);
      #1 reset16 = 1'b0;
      @(posedge clock);
      #1 check("d16_ready", 32'(in_ready16), 1);
      in_left16 = 24'hF00000; in_right16 = 24'h000001; in_valid16 = 1'b1;
      @(posedge clock);
      #1 in_valid16 = 1'b0;
      n = 0;
      while (un16 < 10 && n < 21000) begin
         @(posedge clock);
         n++;
      end
      #1 check("d16_wraps", un16, 10);
      check("d16_bclk_bad", b16_bad, 0);
      check("d16_bclk_edges", b16_edges, 1280);
      check("d16_lrclk_bad", lr16_bad, 0);
      check("d16_lrclk_edges", lr16_edges, LrEdges16);
      check("d16_rises", rise16, 640);
      check("d16_ones", ones16, 50);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2s_dac_tx.md
Name: i2s_dac_tx

Overview:
- Serialises the 24-bit stereo audio samples produced by the Game Boy audio core into I2S for the ADAU1761 codec DAC path.
- Drives ac_bclk, ac_lrclk and ac_dac_sdata; ac_mclk stays on the 12 MHz clock wizard output.
- Runs entirely in the 100 MHz system clock domain. BCLK and LRCLK are generated by clock-enable division, not by a second clock.
- Takes one L/R pair per frame through a valid/ready handshake with a one-entry holding buffer.

Parameters:
- BCLK_DIV, 16: system clocks per BCLK half-period (≥2). fs = f_clk / (128*BCLK_DIV), which gives 48.83 kHz at 100 MHz.
- SAMPLE_W, 24: audio sample width; must be ≤ SLOT_W.

Ports:
- clock, input, 1: system clock, 100 MHz.
- reset, input, 1: synchronous, active-high.
- in_left, input, SAMPLE_W: left sample, two's complement.
- in_right, input, SAMPLE_W: right sample, two's complement.
- in_valid, input, 1: sample pair valid.
- in_ready, output, 1: holding buffer empty.
- bclk, output, 1: to ac_bclk.
- lrclk, output, 1: to ac_lrclk; 0 = left, 1 = right.
- sdata, output, 1: to ac_dac_sdata.
- underrun, output, 1: one-cycle pulse when a frame reuses the previous pair.

Behaviour:
- Reset values (registered): bclk=0, lrclk=1, sdata=0, underrun=0, holding buffer empty (so in_ready=1), state=IDLE, shift registers=0.
- Reset mid-frame aborts the frame immediately. Any pending pair is discarded.
- Handshake: a pair is accepted when in_valid && in_ready. in_ready = !pend_full, combinational from a register. pend_full clears only on a frame load. No bypass: a pair accepted on a load cycle is used for the next frame.
- IDLE: outputs hold their reset values. Move to RUN on the first cycle pend_full=1; that cycle is the first load.
- RUN:
  - div_cnt counts 0..BCLK_DIV-1. At terminal count, bclk toggles.
  - bit_cnt (0..63) advances on every 1→0 toggle. All lrclk/sdata updates happen together with a bclk fall, except the very first load from IDLE.
  - Frame load occurs when bit_cnt wraps 63→0 (or on the IDLE exit). Shift registers load from the buffer if pend_full; otherwise the previous pair is retained and underrun pulses for exactly that cycle.
- Frame format, standard I2S:
  - lrclk=0 for bit_cnt 0..31 and 1 for 32..63.
  - Left MSB is driven at bit_cnt 1, left LSB at bit_cnt SAMPLE_W; right MSB at 33.
  - All other slot bits are 0.
  - The codec samples on the bclk rising edge.
- Widths: samples are passed unmodified, MSB-first. No truncation, since SAMPLE_W ≤ 32.
- Periods: bclk = 2*BCLK_DIV clocks; lrclk = 128*BCLK_DIV clocks, with a 50% duty cycle.
- RUN never returns to IDLE except through reset.

Optional Feature:
- I2S_TX_LEFT_JUSTIFIED_EN
- Defined:
  - Left-justified format: the MSB coincides with the lrclk edge (left MSB at bit_cnt 0, right MSB at 32).
  - lrclk polarity is inverted: 1 = left.
  - The codec register setup must match.
- Undefined: standard I2S exactly as in Behaviour.

Decomposition:
- Package i2s_pkg:
  - SLOT_W=32 and FRAME_BITS=64.
  - The state enum {IDLE, RUN}.
  - Function slot_bit(frame, bit_cnt), which returns the MSB-first bit index or -1 for padding.
- Sub-module i2s_clk_gen: div_cnt/bclk toggling. Outputs bclk, a bclk_fall strobe and bit_cnt; it has an enable input so IDLE holds it at zero.

Test Plan (BCLK_DIV=2 unless stated):
- Send L=0xA55AC3, R=0x123456, then hold valid low. Sampling sdata on bclk rising edges must give: bits 1..24 = 0xA55AC3, bits 33..56 = 0x123456, all other bits 0, lrclk low for bits 0..31.
- No further pairs after the first. Frames 2 and 3 must repeat the same data, and underrun must pulse once per frame at the 63→0 wrap, i.e. every 256 clocks.
- Present pairs P1 and P2 back-to-back, valid held high:
  - P1 is accepted and in_ready drops; P2 waits.
  - P2 is accepted on the load of P1.
  - P2 is transmitted in the frame after P1, with no underrun.
- Assert reset for 1 cycle at bit_cnt 40:
  - Next cycle: bclk=0, lrclk=1, sdata=0, in_ready=1, state IDLE.
  - A new pair then restarts cleanly at bit_cnt 0.
- BCLK_DIV=16 over 10 frames: bclk period = 32 clocks and lrclk period = 2048 clocks exactly, with no glitches.
- I2S_TX_LEFT_JUSTIFIED_EN defined with L=0x800001: the MSB of 1 is at bit_cnt 0 with lrclk=1, the LSB of 1 is at bit_cnt 23, and bit_cnt 24..31 are 0.
